// File: rtl/bcd_scan_if.sv
// Bus bundle between the scan driver and its user: load side, display-scan side,
// and two observation signals (pending flag, current digit index).
interface bcd_scan_if #(
  parameter int NUM_DIGITS = 4
);
  // load is a fire-and-forget strobe with no ready: every load is accepted;
  // load_ack marks the cycle the data reaches the display register.
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [3:0]              bcd_out;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic                    frame_start;
  logic                    load_ack;
  logic                    dbg_pending_valid;
  logic [2:0]              dbg_index;

  modport master (
    output load, digits_in, dp_in,
    input  bcd_out, dp_out, dig_sel, frame_start, load_ack,
    input  dbg_pending_valid, dbg_index
  );

  modport slave (
    input  load, digits_in, dp_in,
    output bcd_out, dp_out, dig_sel, frame_start, load_ack,
    output dbg_pending_valid, dbg_index
  );
endinterface

// File: rtl/bcd_scan_driver.sv
// Multiplexed BCD scan driver with a frame-synchronous double-buffered display register.
// Optional leading-zero blanking is enabled by defining BCD_SCAN_LEADING_ZERO_BLANK_EN.
module bcd_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  bcd_scan_if.slave  bus
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_v_q, pend_v_d;
  logic [3:0]              bcd_out_q, bcd_out_d;
  logic                    dp_out_q, dp_out_d;
  logic [NUM_DIGITS-1:0]   dig_sel_q, dig_sel_d;
  logic                    frame_start_q, frame_start_d;
  logic                    load_ack_q, load_ack_d;

  logic                    tick;
  logic                    boundary;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    zero_above;

  assign tick     = (cnt_q == CNT_W'(SCAN_DIV - 1));
  assign boundary = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));

  // Prescaler, digit index, pending buffer and frame-boundary commit.
  always_comb begin
    cnt_d         = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d         = idx_q;
    disp_d        = disp_q;
    disp_dp_d     = disp_dp_q;
    pend_d        = pend_q;
    pend_dp_d     = pend_dp_q;
    pend_v_d      = pend_v_q;
    load_ack_d    = 1'b0;
    frame_start_d = boundary;

    if (tick) begin
      idx_d = boundary ? '0 : idx_q + IDX_W'(1);
    end

    if (boundary) begin
      // A load landing on the boundary cycle bypasses the pending buffer.
      if (bus.load) begin
        disp_d     = bus.digits_in;
        disp_dp_d  = bus.dp_in;
        load_ack_d = 1'b1;
      end else if (pend_v_q) begin
        disp_d     = pend_q;
        disp_dp_d  = pend_dp_q;
        load_ack_d = 1'b1;
      end
      pend_v_d = 1'b0;
    end else if (bus.load) begin
      pend_d    = bus.digits_in;
      pend_dp_d = bus.dp_in;
      pend_v_d  = 1'b1;
    end
  end

  // Digit k is blank when it and everything above it is zero with no dp set.
  always_comb begin
    lz_blank   = '0;
    zero_above = 1'b1;
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zero_above  = zero_above && (disp_d[4*k +: 4] == 4'd0) && !disp_dp_d[k];
      lz_blank[k] = zero_above;
    end
`endif
  end

  // Output registers track the post-edge index and display contents.
  always_comb begin
    bcd_out_d = 4'd0;
    dp_out_d  = 1'b0;
    dig_sel_d = NUM_DIGITS'(1) << idx_d;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        bcd_out_d = lz_blank[i] ? 4'hF : disp_d[4*i +: 4];
        dp_out_d  = disp_dp_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      disp_q        <= '0;
      disp_dp_q     <= '0;
      pend_q        <= '0;
      pend_dp_q     <= '0;
      pend_v_q      <= 1'b0;
      bcd_out_q     <= 4'd0;
      dp_out_q      <= 1'b0;
      dig_sel_q     <= NUM_DIGITS'(1);
      frame_start_q <= 1'b0;
      load_ack_q    <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      disp_q        <= disp_d;
      disp_dp_q     <= disp_dp_d;
      pend_q        <= pend_d;
      pend_dp_q     <= pend_dp_d;
      pend_v_q      <= pend_v_d;
      bcd_out_q     <= bcd_out_d;
      dp_out_q      <= dp_out_d;
      dig_sel_q     <= dig_sel_d;
      frame_start_q <= frame_start_d;
      load_ack_q    <= load_ack_d;
    end
  end

  assign bus.bcd_out           = bcd_out_q;
  assign bus.dp_out            = dp_out_q;
  assign bus.dig_sel           = dig_sel_q;
  assign bus.frame_start       = frame_start_q;
  assign bus.load_ack          = load_ack_q;
  assign bus.dbg_pending_valid = pend_v_q;
  assign bus.dbg_index         = 3'(idx_q);
endmodule

// File: tb/tb_bcd_scan_driver.sv
// Bench for bcd_scan_driver: directed and random loads, a time-based reference
// model feeding an expected queue, and a per-cycle monitor.
module tb_bcd_scan_driver;
  localparam int S     = 4;
  localparam int N     = 4;
  localparam int FRAME = S * N;

  logic clk;
  logic rst_n;

  bcd_scan_if #(.NUM_DIGITS(N)) bus ();

  bcd_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(S), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  // Record: {pending_valid, load_ack, frame_start, dig_sel[3:0], dp_out, bcd_out[3:0]}
  logic [11:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  localparam logic [11:0] RESET_VEC = {1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 4'h0};

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [11:0] dut_vec();
    return {bus.dbg_pending_valid, bus.load_ack, bus.frame_start,
            bus.dig_sel, bus.dp_out, bus.bcd_out};
  endfunction

  // ---------------- reference model ----------------
  // Everything follows from the number of clock edges since reset: slot k lasts
  // S edges, a frame is FRAME edges, and commits happen at frame ends.
  int unsigned   k_edges;
  logic [15:0]   shown_d, pend_d;
  logic [3:0]    shown_dp, pend_dp;
  bit            pend_v;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_edges  = 0;
      shown_d  = '0;
      shown_dp = '0;
      pend_d   = '0;
      pend_dp  = '0;
      pend_v   = 0;
      exp_q.delete();
    end else begin
      bit          bnd;
      bit          ack;
      int          slot;
      logic [15:0] tmp;
      logic [3:0]  code;
      bnd = (k_edges % FRAME) == FRAME - 1;
      ack = 0;
      if (bnd) begin
        if (bus.load) begin
          shown_d  = bus.digits_in;
          shown_dp = bus.dp_in;
          ack      = 1;
        end else if (pend_v) begin
          shown_d  = pend_d;
          shown_dp = pend_dp;
          ack      = 1;
        end
        pend_v = 0;
      end else if (bus.load) begin
        pend_d  = bus.digits_in;
        pend_dp = bus.dp_in;
        pend_v  = 1;
      end
      k_edges++;
      slot = (k_edges / S) % N;
      tmp  = shown_d >> (4 * slot);
      code = tmp[3:0];
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
      if (slot > 0 && tmp == 16'd0 && (shown_dp >> slot) == 4'd0) code = 4'hF;
`endif
      exp_q.push_back({pend_v, ack, bnd, 4'(1 << slot), shown_dp[slot], code});
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_hold", dut_vec(), RESET_VEC);
    end else if (exp_q.size() > 0) begin
      logic [11:0] e;
      e = exp_q.pop_front();
      check("scan", dut_vec(), e);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
    bus.load      = 1'b1;
    bus.digits_in = d;
    bus.dp_in     = dp;
    @(negedge clk);
    bus.load      = 1'b0;
  endtask

  task automatic wait_phase(input int p);
    int n = 0;
    while ((k_edges % FRAME) != p && n < 64) begin
      @(negedge clk);
      n++;
    end
    if ((k_edges % FRAME) != p) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_phase: phase %0d required %0d", k_edges % FRAME, p);
    end
  endtask

  task automatic async_reset_pulse();
    #1 rst_n = 1'b0;
    #1 check("async_reset", dut_vec(), RESET_VEC);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.load      = 1'b0;
    bus.digits_in = '0;
    bus.dp_in     = '0;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Mid-slot asynchronous reset, then scanning restarts at digit 0.
    repeat (6) @(negedge clk);
    async_reset_pulse();

    // First load before the first boundary.
    do_load(16'h4321, 4'b0000);
    repeat (40) @(negedge clk);

    // Commit 1111, then load 9876 mid-frame.
    wait_phase(3);
    do_load(16'h1111, 4'b0000);
    wait_phase(0);
    wait_phase(6);
    do_load(16'h9876, 4'b0010);
    repeat (40) @(negedge clk);

    // Two loads in one frame: last one wins.
    wait_phase(2);
    do_load(16'h1234, 4'b0000);
    wait_phase(9);
    do_load(16'h5678, 4'b1000);
    repeat (36) @(negedge clk);

    // Load on the boundary cycle commits directly.
    wait_phase(15);
    do_load(16'h2468, 4'b0000);
    repeat (36) @(negedge clk);

    // Leading-zero patterns (blanked only when the option is built in).
    wait_phase(5);
    do_load(16'h0050, 4'b0000);
    repeat (36) @(negedge clk);
    do_load(16'h0050, 4'b0100);
    repeat (36) @(negedge clk);
    do_load(16'h0000, 4'b0000);
    repeat (36) @(negedge clk);

    // Pending data discarded by a mid-frame reset.
    wait_phase(4);
    do_load(16'h7777, 4'b1111);
    repeat (3) @(negedge clk);
    async_reset_pulse();
    repeat (20) @(negedge clk);

    // Random loads, including non-BCD codes and boundary-cycle loads.
    for (int i = 0; i < 40; i++) begin
      logic [15:0] d;
      logic [3:0]  dp;
      d  = 16'($urandom);
      dp = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) wait_phase(15);
      do_load(d, dp);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bcd_scan_driver.md
Name: bcd_scan_driver

Overview:
- Time-multiplexed scan driver that sits directly upstream of the BCD-to-7-segment decoder.
- Holds NUM_DIGITS BCD digits in a double-buffered display register and presents one digit per scan slot on bcd_out, which feeds the decoder's 4-bit input.
- Drives a one-hot digit-enable bus, so a single decoder serves a whole multi-digit common-segment display.
- New values are accepted by a load strobe and committed only on a frame boundary, so the display never tears.

Parameters:
- NUM_DIGITS, 4, number of display digits (2..8).
- SCAN_DIV, 50000, clock cycles each digit stays enabled (>=2).
- CNT_W, 16, prescaler width; must satisfy 2^CNT_W >= SCAN_DIV.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  one-cycle strobe; captures digits_in and dp_in into the pending buffer.
- digits_in  input  4*NUM_DIGITS  BCD digits; [3:0] is digit 0 (least significant, rightmost).
- dp_in  input  NUM_DIGITS  decimal-point request per digit.
- bcd_out  output  4  BCD code of the active digit, to the decoder input.
- dp_out  output  1  decimal point of the active digit.
- dig_sel  output  NUM_DIGITS  one-hot active-high digit enable.
- frame_start  output  1  one-cycle pulse when digit 0 becomes active.
- load_ack  output  1  one-cycle pulse when pending data is committed to the display register.

Behaviour:
- Reset (async, rst_n=0), all immediate:
  - prescaler=0, index=0.
  - display register = 0, dp = 0.
  - pending buffer = 0, pending_valid = 0.
  - bcd_out=0, dp_out=0, dig_sel=1 (digit 0 enabled).
  - frame_start=0, load_ack=0.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - tick = (prescaler==SCAN_DIV-1).
- Digit index:
  - On the tick edge, index advances by 1; NUM_DIGITS-1 wraps to 0.
  - Boundary = tick while index==NUM_DIGITS-1.
- Outputs are all registered and update on the same edge the index changes.
  - They reflect the new index and the display-register contents valid after that edge.
  - No other latency.
- Load:
  - On load=1 the pending buffer captures digits_in/dp_in and pending_valid is set.
  - A second load before the boundary overwrites the buffer (last wins); no error.
- Commit:
  - At the boundary edge with pending_valid=1, the display register takes the pending data.
  - pending_valid clears and load_ack pulses for exactly one cycle.
  - The new data is shown starting with digit 0 of the new frame.
- load asserted on the boundary cycle: digits_in/dp_in commit directly at that edge; load_ack pulses and pending_valid stays 0.
- Boundary with no pending data: the display register holds its value and load_ack stays 0.
- frame_start pulses for one cycle after each boundary edge, aligned with dig_sel becoming 1.
- Digit codes >9 pass through unchanged; the downstream decoder blanks them.
- dig_sel is always exactly one-hot, including immediately after reset.
- Reset mid-frame discards pending data and restarts scanning at digit 0.

Optional Feature:
- Macro: BCD_SCAN_LEADING_ZERO_BLANK_EN.
- When defined, digit k>0 outputs bcd_out=4'hF (blank at the decoder) when all of the following hold:
  - its value is 0;
  - every more-significant digit is 0;
  - its dp bit and the dp bits of all more-significant digits are clear.
- Digit 0 is never blanked.
- Blanking is computed from the committed display register and does not alter timing.
- When undefined, all digits are shown as stored, zeros included.

Test Plan:
- SCAN_DIV=4, NUM_DIGITS=4: assert rst_n=0 asynchronously mid-slot -> outputs immediately read dig_sel=0001, bcd_out=0, load_ack=0; scanning resumes from digit 0 after release.
- load with digits_in=16'h4321 before the first boundary -> load_ack at the boundary, then dig_sel 0001/0010/0100/1000 held 4 cycles each, with bcd_out 1/2/3/4; frame_start on each return to 0001.
- Commit 16'h1111, then load 16'h9876 mid-frame -> current frame still shows 1,1,1,1; next frame shows 6,7,8,9; exactly one load_ack.
- Two loads in one frame (16'h1234, then 16'h5678) -> only 8,7,6,5 is ever displayed; one load_ack.
- load 16'h2468 on the boundary cycle -> committed at that edge; the following frame shows 8,6,4,2; pending_valid stays 0.
- With BCD_SCAN_LEADING_ZERO_BLANK_EN defined, commit 16'h0050, dp_in=0 -> bcd_out sequence 0,5,F,F; with dp_in=4'b0100 -> 0,5,0,F.
